npu_cube_acc_requant: RTL
=========================

Name: npu_cube_acc_requant

Overview:
- Sits directly downstream of the 8-lane Booth add tree.
- Consumes one signed 19-bit dot-product partial (8 int8×int8 products) per beat and accumulates a programmable number of partials into a wide accumulator, covering K > 8 reductions.
- Rounds, shifts, optionally ReLUs and saturates the sum to int8, then presents it with a valid/ready handshake to the output writeback stage.

Parameters:
DWIN, 19, width of incoming signed partial sum
DWACC, 32, accumulator width (signed)
DWOUT, 8, requantized output width (signed)
LENW, 12, width of accumulation-length field
SHW, 5, width of right-shift field

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; latches cfg_* and begins a job (honoured only in IDLE)
cfg_len  input  LENW  number of partials to accumulate; 0 treated as 1
cfg_shift  input  SHW  arithmetic right shift applied before saturation
cfg_relu  input  1  clamp negative results to 0 (see Optional Feature)
in_data  input  DWIN  signed partial sum from add tree
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data
out_data  output  DWOUT  requantized signed result
out_acc  output  DWACC  raw accumulator value, before requantization
out_ovf  output  1  sticky: accumulator saturated during this job
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
busy  output  1  high in ACC or OUT

Behaviour:
- Reset values: state=IDLE; accumulator, count, out_data, out_acc, out_ovf, out_valid all 0; in_ready=0; busy=0.
- Reset asserted mid-job aborts the job immediately and discards any partial sum.
- IDLE:
  - start=1 latches len=(cfg_len==0?1:cfg_len), shift and relu; clears acc, count and ovf; next state ACC.
  - in_valid is ignored in IDLE.
- ACC:
  - in_ready=1. A beat fires when in_valid&in_ready.
  - On each beat, in_data is sign-extended to DWACC and added to acc with signed saturation at ±(2^(DWACC-1)); any saturation sets ovf. count increments.
  - On the beat where count+1==len, the state moves to OUT and the registered result appears on the next cycle. Latency is 1 cycle from the last beat to out_valid=1.
- Requant (computed from the final acc, registered into out_data):
  - r = acc + (shift>0 ? 1<<(shift-1) : 0), saturating.
  - r = r >>> shift.
  - If relu and r<0, r=0.
  - Saturate r to [-2^(DWOUT-1), 2^(DWOUT-1)-1].
  - shift ≥ DWACC yields 0 for non-negative acc and -1 for negative acc (before ReLU).
- OUT:
  - in_ready=0; out_valid=1. out_data, out_acc and out_ovf are held stable until out_ready.
  - On out_valid&out_ready the state moves to IDLE and out_valid deasserts the next cycle.
- start asserted in ACC or OUT is ignored; no queuing.
- busy=1 in ACC and OUT.

Optional Feature:
- Macro NPU_CUBE_ACC_RELU_EN.
- Defined: cfg_relu is latched at start and the ReLU clamp is applied as described.
- Undefined: cfg_relu is ignored, no ReLU logic is synthesized, and negative results pass to saturation unchanged.
- The port list is identical in both builds.

Test Plan:
1. len=3, shift=0, inputs 10, 20, -5 with in_valid continuous → out_valid 1 cycle after the 3rd beat; out_acc=25, out_data=25, out_ovf=0.
2. len=2, shift=4, inputs 1000, 1000 → out_acc=2000; (2000+8)>>>4=125, out_data=125. Inputs 2047, 2047 (sum 4094) → out_data=127 (saturated), out_ovf=0.
3. len=1, shift=2, relu=1, input -262144 → with NPU_CUBE_ACC_RELU_EN out_data=0; without it out_data=-128; out_acc=-262144 in both builds.
4. Backpressure: len=1, out_ready held 0 for 5 cycles → out_valid, out_data and out_acc stable and in_ready=0 throughout; a second start pulse during this window is ignored; out_ready=1 → IDLE next cycle.
5. cfg_len=0 behaves as len=1. in_valid toggling 1,0,1,0 with len=2 accumulates only valid beats (7, then 9 → out_acc=16). DWACC=20 override with len=8 × 262143 → out_acc=524287, out_ovf=1.
6. rst asserted after 2 of 4 beats → all outputs 0 and state IDLE next cycle. A new start with len=1, input 5 → out_acc=5, with no carry-over from the aborted job.

Source files
------------

// File: rtl/npu_cube_acc_requant.sv
// Accumulates signed add-tree partials over a programmable length, then rounds, shifts and saturates to int8.
// Optional ReLU clamp is built only when NPU_CUBE_ACC_RELU_EN is defined.
module npu_cube_acc_requant #(
  parameter int unsigned DWIN  = 19,
  parameter int unsigned DWACC = 32,
  parameter int unsigned DWOUT = 8,
  parameter int unsigned LENW  = 12,
  parameter int unsigned SHW   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LENW-1:0]         cfg_len,
  input  logic [SHW-1:0]          cfg_shift,
  input  logic                    cfg_relu,
  input  logic signed [DWIN-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [DWOUT-1:0] out_data,
  output logic signed [DWACC-1:0] out_acc,
  output logic                    out_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic signed [DWACC-1:0] ACC_MAX = {1'b0, {(DWACC-1){1'b1}}};
  localparam logic signed [DWACC-1:0] ACC_MIN = {1'b1, {(DWACC-1){1'b0}}};
  localparam logic signed [DWACC-1:0] OUT_MAX = {{(DWACC-DWOUT+1){1'b0}}, {(DWOUT-1){1'b1}}};
  localparam logic signed [DWACC-1:0] OUT_MIN = {{(DWACC-DWOUT+1){1'b1}}, {(DWOUT-1){1'b0}}};

  state_t                  state;
  logic signed [DWACC-1:0] acc;
  logic [LENW-1:0]         count;
  logic [LENW-1:0]         len;
  logic [SHW-1:0]          shift;
  logic                    ovf;
`ifdef NPU_CUBE_ACC_RELU_EN
  logic                    relu;
`else
  logic                    unused_relu;
  assign unused_relu = cfg_relu;
`endif

  logic                    beat_c;
  logic [DWACC:0]          sum_wide_c;
  logic signed [DWACC-1:0] acc_nxt_c;
  logic                    sat_c;
  logic [DWACC:0]          rnd_c;
  logic [DWACC:0]          rsum_c;
  logic signed [DWACC-1:0] r_sat_c;
  logic signed [DWACC-1:0] r_sh_c;
  logic signed [DWACC-1:0] r_cl_c;
  logic signed [DWOUT-1:0] q_c;

  assign beat_c = in_valid && in_ready;

  // Saturating accumulate: overflow shows as disagreement between the guard bit and the sign bit
  always_comb begin
    sum_wide_c = {acc[DWACC-1], acc} + {{(DWACC+1-DWIN){in_data[DWIN-1]}}, in_data};
    sat_c      = sum_wide_c[DWACC] != sum_wide_c[DWACC-1];
    acc_nxt_c  = sum_wide_c[DWACC-1:0];
    if (sat_c) acc_nxt_c = sum_wide_c[DWACC] ? ACC_MIN : ACC_MAX;
  end

  // Requantize the post-beat accumulator so the result can register on the last beat
  always_comb begin
    rnd_c = '0;
    if (shift != '0) rnd_c = (DWACC+1)'(1) << (shift - SHW'(1));
    rsum_c  = {acc_nxt_c[DWACC-1], acc_nxt_c} + rnd_c;
    r_sat_c = rsum_c[DWACC-1:0];
    if (rsum_c[DWACC] != rsum_c[DWACC-1]) r_sat_c = ACC_MAX;
    r_sh_c = r_sat_c >>> shift;
    if (32'(shift) >= DWACC) r_sh_c = acc_nxt_c[DWACC-1] ? '1 : '0;
`ifdef NPU_CUBE_ACC_RELU_EN
    if (relu && r_sh_c < 0) r_sh_c = '0;
`endif
    r_cl_c = r_sh_c;
    if (r_sh_c > OUT_MAX) r_cl_c = OUT_MAX;
    else if (r_sh_c < OUT_MIN) r_cl_c = OUT_MIN;
    q_c = r_cl_c[DWOUT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      len       <= '0;
      shift     <= '0;
      ovf       <= 1'b0;
`ifdef NPU_CUBE_ACC_RELU_EN
      relu      <= 1'b0;
`endif
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len      <= (cfg_len == '0) ? LENW'(1) : cfg_len;
            shift    <= cfg_shift;
`ifdef NPU_CUBE_ACC_RELU_EN
            relu     <= cfg_relu;
`endif
            acc      <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACC;
          end
        end
        ACC: begin
          if (beat_c) begin
            acc   <= acc_nxt_c;
            ovf   <= ovf | sat_c;
            count <= count + LENW'(1);
            if (count + LENW'(1) == len) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= q_c;
              out_acc   <= acc_nxt_c;
              out_ovf   <= ovf | sat_c;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
